// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, one bit per cycle, with the sign fix applied on entry to DONE.
//
//   state | meaning
//   IDLE  | waiting for a start; resolves divide special cases immediately
//   CALC  | one multiply/divide bit per cycle, WIDTH cycles
//   DONE  | result valid; held while StallE=1
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MulDivStartE,
    input  logic [2:0]       funct3E,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             StallE,
    input  logic             FlushE,
    output logic             MulDivBusyE,
    output logic             MulDivDoneE,
    output logic [WIDTH-1:0] MulDivResultE
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic             a_neg_q, b_neg_q;
    logic [WIDTH-1:0] mag_a_q, mag_b_q, acc_hi_q, acc_lo_q, result_q;
    logic [CW-1:0]    cnt_q;

    logic             sign_a, sign_b, in_a_neg, in_b_neg, div_zero, div_ovf, special, start_ok;
    logic [WIDTH-1:0] in_mag_a, in_mag_b, special_res;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo, quot_fix, rem_fix, calc_res;
    logic [2*WIDTH-1:0] prod, prod_fix;

    // Operand decode in IDLE: magnitudes and the divide shortcuts.
    always_comb begin
        sign_a   = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] != 2'b11);
        sign_b   = funct3E[2] ? ~funct3E[0] : ~funct3E[1];
        in_a_neg = sign_a & SrcAE[WIDTH-1];
        in_b_neg = sign_b & SrcBE[WIDTH-1];
        in_mag_a = in_a_neg ? -SrcAE : SrcAE;
        in_mag_b = in_b_neg ? -SrcBE : SrcBE;
        div_zero = funct3E[2] & (SrcBE == '0);
        div_ovf  = funct3E[2] & ~funct3E[0] & (SrcAE == MOST_NEG) & (SrcBE == '1);
        special  = div_zero | div_ovf;
        start_ok = MulDivStartE & ~FlushE;
        if (div_zero)
            special_res = funct3E[1] ? SrcAE : '1;
        else
            special_res = funct3E[1] ? '0 : SrcAE;
    end

    // One iteration; the last one feeds the result register directly.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_a_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, mag_b_q};
        if (op_q[2]) begin
            step_hi = div_ok ? WIDTH'(div_shift - {1'b0, mag_b_q}) : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
        quot_fix = (a_neg_q ^ b_neg_q) ? -step_lo : step_lo;
        rem_fix  = a_neg_q ? -step_hi : step_hi;
        case (op_q)
            3'b000:                 calc_res = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: calc_res = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         calc_res = quot_fix;
            default:                calc_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        MulDivBusyE = 1'b0;
        MulDivDoneE = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    MulDivBusyE = 1'b1;
                    state_nx    = special ? DONE : CALC;
                end
            end
            CALC: begin
                MulDivBusyE = ~FlushE;
                if (FlushE)                  state_nx = IDLE;
                else if (cnt_q == CW'(1))    state_nx = DONE;
            end
            DONE: begin
                MulDivDoneE = ~FlushE;
                if (FlushE || !StallE)       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (state == IDLE && start_ok) begin
            op_q     <= funct3E;
            a_neg_q  <= in_a_neg;
            b_neg_q  <= in_b_neg;
            mag_a_q  <= in_mag_a;
            mag_b_q  <= in_mag_b;
            acc_hi_q <= '0;
            acc_lo_q <= funct3E[2] ? in_mag_a : in_mag_b;
            cnt_q    <= CW'(WIDTH);
            if (special) result_q <= special_res;
        end else if (state == CALC && !FlushE) begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) result_q <= calc_res;
        end
    end

    assign MulDivResultE = result_q;
endmodule
